// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master: the side that issues operands and consumes results.
// slave:  the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// using a single full-subtractor cell. Operands in and result out over
// valid/ready handshakes carried by serial_subtractor_if.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the signed-overflow flag
// on Ovf; without it Ovf is tied low and no extra flops are built.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  // Lower result bits collected so far; the final bit is appended when the
  // result is published, so only WIDTH-1 bits need to be stored here.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_full;
  logic             w_in_ready;
  logic             w_out_valid;

  // One full-subtractor cell acting on the current LSBs.
  assign w_d           = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
  assign w_borrow_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
  assign w_res_full    = {w_d, r_res};
  assign w_accept      = (r_state == S_IDLE) && bus.start;
  assign w_last        = (r_state == S_RUN) && (r_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; start is only looked at in IDLE, so a
  // start coinciding with out_ready in DONE is simply dropped.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand shifters, borrow chain, bit counter and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= bus.A;
      r_b_sh   <= bus.B;
      r_borrow <= bus.Bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_borrow <= w_borrow_next;
      r_res    <= w_res_full[WIDTH-1:1];
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res_full;
        r_bout <= w_borrow_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow: operands of different sign and result sign differs from A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= bus.A[WIDTH-1];
      r_b_msb <= bus.B[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign bus.Ovf = r_ovf;
`else
  assign bus.Ovf = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.Diff      = r_diff;
  assign bus.Bout      = r_bout;

endmodule
